// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive observer for a red/yellow/green traffic-light
// interface. It registers the lamp wires, locks an FSM to the current phase,
// measures phase durations, checks phase order and lamp encoding, and keeps
// sticky error flags plus a wrapping count of completed light cycles.
//
// Optional build macro: SEMAFORO_MON_DUR_CHECK_EN
//   defined   -> duration range checks, overrun detection and dur_err_o
//   undefined -> that logic is absent and dur_err_o is tied to 0
module semaforo_monitor #(
   parameter int GREEN_TICKS  = 61,
   parameter int YELLOW_TICKS = 6,
   parameter int RED_TICKS    = 56,
   parameter int TOL          = 0,
   parameter int CNT_W        = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             red_i,
   input  logic             green_i,
   input  logic             yellow_i,
   input  logic             err_clr_i,
   output logic [1:0]       phase_o,
   output logic             phase_valid_o,
   output logic             seq_err_o,
   output logic             lamp_err_o,
   output logic             dur_err_o,
   output logic [CNT_W-1:0] last_dur_o,
   output logic [15:0]      cycles_o
);

   // State encoding doubles as the phase_o code.
   typedef enum logic [1:0] {
      ST_GREEN  = 2'b00,
      ST_YELLOW = 2'b01,
      ST_RED    = 2'b10,
      ST_SYNC   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Duration counter stops at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // The only legal successor of each phase.
   function automatic state_t legal_next(input state_t s);
      case (s)
         ST_GREEN:  return ST_YELLOW;
         ST_YELLOW: return ST_RED;
         ST_RED:    return ST_GREEN;
         default:   return ST_SYNC;
      endcase
   endfunction

   logic [2:0]       lamp_q;          // {red, yellow, green}
   logic             lamp_onehot;
   state_t           lamp_st;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
   logic [CNT_W-1:0] last_dur_q, last_dur_d;
   logic             partial_q, partial_d;
   logic [15:0]      cycles_q, cycles_d;
   logic             seq_err_q, seq_err_d;
   logic             lamp_err_q, lamp_err_d;
   logic             seq_set, lamp_set;

   // Input register: every decision below is made on the sampled lamps.
   always_ff @(posedge clk_i) begin
      if (rst_i) lamp_q <= 3'b000;
      else       lamp_q <= {red_i, yellow_i, green_i};
   end

   // Decode the sampled lamps into a phase, flagging anything not one-hot.
   always_comb begin
      lamp_onehot = 1'b1;
      lamp_st     = ST_SYNC;
      case (lamp_q)
         3'b001:  lamp_st = ST_GREEN;
         3'b010:  lamp_st = ST_YELLOW;
         3'b100:  lamp_st = ST_RED;
         default: lamp_onehot = 1'b0;
      endcase
   end

   // Next-state logic: phase tracking, duration count, order and lamp checks.
   always_comb begin
      state_d    = state_q;
      dur_cnt_d  = dur_cnt_q;
      last_dur_d = last_dur_q;
      partial_d  = partial_q;
      cycles_d   = cycles_q;
      seq_set    = 1'b0;
      lamp_set   = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (lamp_onehot) begin
               state_d   = lamp_st;
               dur_cnt_d = CNT_ONE;
               partial_d = 1'b1;
            end
         end
         default: begin
            if (!lamp_onehot) begin
               lamp_set = 1'b1;
               state_d  = ST_SYNC;
            end else if (lamp_st == state_q) begin
               dur_cnt_d = sat_inc(dur_cnt_q);
            end else begin
               last_dur_d = dur_cnt_q;
               dur_cnt_d  = CNT_ONE;
               state_d    = lamp_st;
               if (lamp_st == legal_next(state_q)) begin
                  partial_d = 1'b0;
                  if (state_q == ST_RED) cycles_d = cycles_q + 16'd1;
               end else begin
                  // Follow the observed lamp, but its length is untrustworthy.
                  partial_d = 1'b1;
                  seq_set   = 1'b1;
               end
            end
         end
      endcase
   end

   // Sticky flags: a set event in the clear cycle keeps the flag high.
   assign seq_err_d  = (seq_err_q  & ~err_clr_i) | seq_set;
   assign lamp_err_d = (lamp_err_q & ~err_clr_i) | lamp_set;

   // FSM and bookkeeping registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_SYNC;
         dur_cnt_q  <= '0;
         last_dur_q <= '0;
         partial_q  <= 1'b1;
         cycles_q   <= '0;
         seq_err_q  <= 1'b0;
         lamp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dur_cnt_q  <= dur_cnt_d;
         last_dur_q <= last_dur_d;
         partial_q  <= partial_d;
         cycles_q   <= cycles_d;
         seq_err_q  <= seq_err_d;
         lamp_err_q <= lamp_err_d;
      end
   end

`ifdef SEMAFORO_MON_DUR_CHECK_EN
   function automatic int exp_ticks(input state_t s);
      case (s)
         ST_GREEN:  return GREEN_TICKS;
         ST_YELLOW: return YELLOW_TICKS;
         default:   return RED_TICKS;
      endcase
   endfunction

   // Lower bound clamps at zero so a large TOL cannot underflow.
   function automatic int lo_bound(input int e);
      return (e > TOL) ? e - TOL : 0;
   endfunction

   logic dur_err_q, dur_err_d;
   logic ovr_q, ovr_d;
   logic dur_set, trans, hold;
   int   lo_v, hi_v;

   // Range check on leaving a full phase; overrun reported once while in it.
   always_comb begin
      lo_v    = lo_bound(exp_ticks(state_q));
      hi_v    = exp_ticks(state_q) + TOL;
      trans   = (state_q != ST_SYNC) && (state_d != ST_SYNC) && (state_d != state_q);
      hold    = (state_q != ST_SYNC) && (state_d == state_q);
      dur_set = 1'b0;
      ovr_d   = 1'b0;
      if (hold) begin
         ovr_d = ovr_q;
         if (!partial_q && !ovr_q && (int'(dur_cnt_d) > hi_v)) begin
            dur_set = 1'b1;
            ovr_d   = 1'b1;
         end
      end
      if (trans && !partial_q &&
          ((int'(dur_cnt_q) < lo_v) || (int'(dur_cnt_q) > hi_v)))
         dur_set = 1'b1;
      dur_err_d = (dur_err_q & ~err_clr_i) | dur_set;
   end

   // Duration flag and per-phase overrun marker.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dur_err_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         dur_err_q <= dur_err_d;
         ovr_q     <= ovr_d;
      end
   end

   assign dur_err_o = dur_err_q;
`else
   assign dur_err_o = 1'b0;
`endif

   assign phase_o       = state_q;
   assign phase_valid_o = (state_q != ST_SYNC);
   assign seq_err_o     = seq_err_q;
   assign lamp_err_o    = lamp_err_q;
   assign last_dur_o    = last_dur_q;
   assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: legal cycles, duration overrun,
// sequence and lamp errors, clear-vs-set priority, and reset mid-phase.
module tb_semaforo_monitor;

`ifdef SEMAFORO_MON_DUR_CHECK_EN
   localparam logic DUR_EN = 1'b1;
`else
   localparam logic DUR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       red, green, yellow, err_clr;
   logic [1:0] phase;
   logic       phase_valid, seq_err, lamp_err, dur_err;
   logic [7:0] last_dur;
   logic [15:0] cycles;

   int total = 0;
   int bad   = 0;

   semaforo_monitor dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .red_i         (red),
      .green_i       (green),
      .yellow_i      (yellow),
      .err_clr_i     (err_clr),
      .phase_o       (phase),
      .phase_valid_o (phase_valid),
      .seq_err_o     (seq_err),
      .lamp_err_o    (lamp_err),
      .dur_err_o     (dur_err),
      .last_dur_o    (last_dur),
      .cycles_o      (cycles)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lamps(input logic r, input logic g, input logic y);
      red = r; green = g; yellow = y;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_phase"}, 32'(phase), 32'd3);
      chk({tag, "_valid"}, 32'(phase_valid), 32'd0);
      chk({tag, "_seq"},   32'(seq_err), 32'd0);
      chk({tag, "_lamp"},  32'(lamp_err), 32'd0);
      chk({tag, "_dur"},   32'(dur_err), 32'd0);
      chk({tag, "_last"},  32'(last_dur), 32'd0);
      chk({tag, "_cyc"},   32'(cycles), 32'd0);
   endtask

   initial begin
      rst = 1'b1; err_clr = 1'b0;
      lamps(0, 0, 0);
      cyc(3);
      rst = 1'b0;
      cyc(1);
      chk_reset("rst");

      // Legal run: G61 Y6 R56 twice, then green.
      lamps(0, 1, 0); cyc(2);
      chk("g1_phase", 32'(phase), 32'd0);
      chk("g1_valid", 32'(phase_valid), 32'd1);
      chk("g1_last", 32'(last_dur), 32'd0);
      cyc(59);
      lamps(0, 0, 1); cyc(2);
      chk("y1_phase", 32'(phase), 32'd1);
      chk("y1_last", 32'(last_dur), 32'd61);
      cyc(4);
      lamps(1, 0, 0); cyc(2);
      chk("r1_phase", 32'(phase), 32'd2);
      chk("r1_last", 32'(last_dur), 32'd6);
      cyc(54);
      lamps(0, 1, 0); cyc(2);
      chk("g2_phase", 32'(phase), 32'd0);
      chk("g2_last", 32'(last_dur), 32'd56);
      chk("g2_cyc", 32'(cycles), 32'd1);
      cyc(59);
      lamps(0, 0, 1); cyc(2);
      chk("y2_last", 32'(last_dur), 32'd61);
      cyc(4);
      lamps(1, 0, 0); cyc(2);
      chk("r2_last", 32'(last_dur), 32'd6);
      cyc(54);
      lamps(0, 1, 0); cyc(2);
      chk("g3_phase", 32'(phase), 32'd0);
      chk("g3_last", 32'(last_dur), 32'd56);
      chk("g3_cyc", 32'(cycles), 32'd2);
      chk("g3_seq", 32'(seq_err), 32'd0);
      chk("g3_lamp", 32'(lamp_err), 32'd0);
      chk("g3_dur", 32'(dur_err), 32'd0);
      cyc(59);

      // Yellow held 7 clocks: overrun at count 7.
      lamps(0, 0, 1); cyc(2);
      chk("y7_phase", 32'(phase), 32'd1);
      cyc(5);
      chk("y7_pre_ovr", 32'(dur_err), 32'd0);
      lamps(1, 0, 0); cyc(1);
      chk("y7_ovr", 32'(dur_err), 32'(DUR_EN));
      chk("y7_still_y", 32'(phase), 32'd1);
      cyc(1);
      chk("y7_r_phase", 32'(phase), 32'd2);
      chk("y7_last", 32'(last_dur), 32'd7);
      chk("y7_seq", 32'(seq_err), 32'd0);
      cyc(54);
      lamps(0, 1, 0); cyc(2);
      chk("g4_cyc", 32'(cycles), 32'd3);
      chk("g4_dur_sticky", 32'(dur_err), 32'(DUR_EN));
      err_clr = 1'b1; cyc(1); err_clr = 1'b0;
      chk("g4_dur_clr", 32'(dur_err), 32'd0);
      cyc(58);

      // Green -> red directly; red of 30 is partial and unchecked.
      lamps(1, 0, 0); cyc(2);
      chk("seq_phase", 32'(phase), 32'd2);
      chk("seq_err", 32'(seq_err), 32'd1);
      chk("seq_last", 32'(last_dur), 32'd61);
      cyc(28);
      lamps(0, 1, 0); cyc(2);
      chk("seq_g_phase", 32'(phase), 32'd0);
      chk("seq_g_cyc", 32'(cycles), 32'd4);
      chk("seq_g_last", 32'(last_dur), 32'd30);
      chk("seq_g_dur", 32'(dur_err), 32'd0);
      cyc(18);

      // One-clock 011 glitch mid-green.
      lamps(0, 1, 1); cyc(1);
      lamps(0, 1, 0); cyc(1);
      chk("gl_phase", 32'(phase), 32'd3);
      chk("gl_valid", 32'(phase_valid), 32'd0);
      chk("gl_lamp", 32'(lamp_err), 32'd1);
      cyc(1);
      chk("gl_relock", 32'(phase), 32'd0);
      chk("gl_relock_v", 32'(phase_valid), 32'd1);
      cyc(8);
      lamps(0, 0, 1); cyc(2);
      chk("gl_y_last", 32'(last_dur), 32'd10);
      chk("gl_y_dur", 32'(dur_err), 32'd0);
      err_clr = 1'b1; cyc(1); err_clr = 1'b0;
      chk("clr_seq", 32'(seq_err), 32'd0);
      chk("clr_lamp", 32'(lamp_err), 32'd0);
      cyc(3);

      // Yellow -> green illegal, with clear asserted on the same edge.
      lamps(0, 1, 0); cyc(1);
      err_clr = 1'b1; cyc(1); err_clr = 1'b0;
      chk("cs_seq_set", 32'(seq_err), 32'd1);
      chk("cs_phase", 32'(phase), 32'd0);
      chk("cs_last", 32'(last_dur), 32'd6);
      chk("cs_dur", 32'(dur_err), 32'd0);
      err_clr = 1'b1; cyc(1); err_clr = 1'b0;
      chk("cs_seq_clr", 32'(seq_err), 32'd0);
      cyc(17);

      // Reset 20 clocks into red; the rest of that red is partial.
      lamps(0, 0, 1); cyc(6);
      lamps(1, 0, 0); cyc(2);
      chk("rr_phase", 32'(phase), 32'd2);
      cyc(18);
      rst = 1'b1; cyc(1);
      chk_reset("mid");
      rst = 1'b0; cyc(2);
      chk("rr2_phase", 32'(phase), 32'd2);
      chk("rr2_valid", 32'(phase_valid), 32'd1);
      cyc(34);
      lamps(0, 1, 0); cyc(2);
      chk("rr_g_phase", 32'(phase), 32'd0);
      chk("rr_g_last", 32'(last_dur), 32'd36);
      chk("rr_g_cyc", 32'(cycles), 32'd1);
      chk("rr_g_dur", 32'(dur_err), 32'd0);
      chk("rr_g_seq", 32'(seq_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
